// File: rtl/cache_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module      : cache_arbiter_pkg
// Description : Shared types and constants for the I/D cache-to-memory
//               arbiter: FSM state encoding, grant encoding and the
//               line-offset helper.
// Revision    : 1.0 - initial release
//==============================================================================
package cache_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam int LINE_WIDTH_DEFAULT = 256;
    localparam int ADDR_WIDTH_DEFAULT = 32;

    // Number of byte-offset bits inside one cache line.
    function automatic int line_offset_bits(input int line_width);
        return $clog2(line_width / 8);
    endfunction

    localparam int OFFSET_BITS = line_offset_bits(LINE_WIDTH_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/cache_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module      : cache_arbiter_if
// Description : Bundle of the I-cache miss port, D-cache miss port and the
//               physical-memory line port seen by the arbiter.
//   I side : i_read, i_addr -> ; <- i_rdata, i_resp
//   D side : d_read, d_write, d_addr, d_wdata -> ; <- d_rdata, d_resp
//   Memory : <- mem_read, mem_write, mem_addr, mem_wdata ; mem_rdata, mem_resp ->
//   slave  : arbiter view;  master : caches + memory view.
// Revision    : 1.0 - initial release
//==============================================================================
interface cache_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/cache_arbiter_arb_rr2.sv
`default_nettype none
//==============================================================================
// Module      : arb_rr2
// Description : Two-requester round-robin picker. The pick is combinational;
//               the last-grant register advances only when the pick is
//               accepted by the parent.
//   i_req_i / i_req_d : pending requests
//   i_accept          : parent consumed the current pick
//   o_valid / o_grant : a request is pending / which side wins
// Revision    : 1.0 - initial release
//==============================================================================
module arb_rr2
    import cache_arbiter_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_req_i,
    input  wire logic i_req_d,
    input  wire logic i_accept,
    output logic      o_valid,
    output grant_t    o_grant
);

    grant_t r_last_grant;

    // Reset to D so that the very first contention goes to I.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GNT_D;
        end else if (i_accept) begin
            r_last_grant <= o_grant;
        end
    end

    always_comb begin
        o_valid = i_req_i | i_req_d;
        o_grant = GNT_I;
        if (i_req_i && i_req_d) begin
            o_grant = (r_last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (i_req_d) begin
            o_grant = GNT_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : cache_arbiter
// Description : Serialises I-cache line fills and D-cache fills/writebacks
//               onto one memory line port. Round-robin on contention; the
//               granted request is latched, served until mem_resp, and a
//               one-cycle response pulse is returned to the requester.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cache_arbiter_if.slave (I side, D side, memory port)
// Revision    : 1.0 - initial release
//==============================================================================
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    cache_arbiter_if.slave   bus
);

    localparam int                    OFF_BITS    = line_offset_bits(LINE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] C_OFF_MASK  = ADDR_WIDTH'((1 << OFF_BITS) - 1);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;

    logic                  w_i_req;
    logic                  w_d_req;
    logic                  w_pick_valid;
    grant_t                w_pick;
    logic                  w_grant_en;
    logic [ADDR_WIDTH-1:0] w_req_addr;

    logic                  r_is_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_i_rdata;
    logic [LINE_WIDTH-1:0] r_d_rdata;

    logic                  w_serving;
    logic                  w_mem_read;
    logic                  w_mem_write;
    logic                  w_i_resp;
    logic                  w_d_resp;

    // A simultaneous d_read/d_write counts as one D request (writeback wins).
    assign w_i_req    = bus.i_read;
    assign w_d_req    = bus.d_read | bus.d_write;
    assign w_grant_en = (r_state == IDLE) && w_pick_valid;
    assign w_req_addr = (w_pick == GNT_D) ? bus.d_addr : bus.i_addr;

    arb_rr2 u_arb_rr2 (
        .clk      (clk),
        .rst      (rst),
        .i_req_i  (w_i_req),
        .i_req_d  (w_d_req),
        .i_accept (w_grant_en),
        .o_valid  (w_pick_valid),
        .o_grant  (w_pick)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = (w_pick == GNT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                if (bus.mem_resp) begin
                    w_state_nxt = RESP_I;
                end
            end
            SERVE_D: begin
                if (bus.mem_resp) begin
                    w_state_nxt = RESP_D;
                end
            end
            RESP_I:  w_state_nxt = IDLE;
            RESP_D:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Memory strobes decode straight from state so they fall as soon as the
    // FSM leaves SERVE_x (including on asynchronous reset).
    always_comb begin
        w_serving   = (r_state == SERVE_I) || (r_state == SERVE_D);
        w_mem_read  = w_serving && !r_is_write;
        w_mem_write = w_serving &&  r_is_write;
        w_i_resp    = (r_state == RESP_I);
        w_d_resp    = (r_state == RESP_D);
    end

    // ---------------- Datapath latches ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_grant_en) begin
                r_is_write <= (w_pick == GNT_D) && bus.d_write;
                r_addr     <= w_req_addr & ~C_OFF_MASK;
                r_wdata    <= bus.d_wdata;
            end
            // Each side owns its own buffer; a writeback leaves d_rdata as is.
            if ((r_state == SERVE_I) && bus.mem_resp) begin
                r_i_rdata <= bus.mem_rdata;
            end
            if ((r_state == SERVE_D) && bus.mem_resp && !r_is_write) begin
                r_d_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.i_resp    = w_i_resp;
    assign bus.d_resp    = w_d_resp;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_cache_arbiter
// Description : Self-checking bench for cache_arbiter. A transaction-level
//               model predicts the outputs every cycle; directed scenarios
//               add hand-computed literal expectations.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;
    localparam logic [AW-1:0] C_LINE_MASK = AW'(LW / 8 - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    cache_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One outstanding transaction at most; m_resp: 0 none, 1 I, 2 D.
    bit            m_busy, m_side, m_write, m_last;
    int            m_resp;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_irdata, m_drdata;

    // Returns 1 when D wins. last: 1 means D was granted last.
    function automatic bit winner(input bit ireq, input bit dreq, input bit last);
        if (ireq && dreq) return !last;
        return dreq;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_side   <= 1'b0;
            m_write  <= 1'b0;
            m_last   <= 1'b1;
            m_resp   <= 0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_irdata <= '0;
            m_drdata <= '0;
        end else if (m_resp != 0) begin
            m_resp <= 0;
        end else if (m_busy) begin
            if (bus.mem_resp) begin
                m_busy <= 1'b0;
                m_resp <= m_side ? 2 : 1;
                if (!m_write) begin
                    if (m_side) m_drdata <= bus.mem_rdata;
                    else        m_irdata <= bus.mem_rdata;
                end
            end
        end else if (bus.i_read || bus.d_read || bus.d_write) begin
            m_busy  <= 1'b1;
            m_side  <= winner(bus.i_read, bus.d_read | bus.d_write, m_last);
            m_last  <= winner(bus.i_read, bus.d_read | bus.d_write, m_last);
            m_write <= winner(bus.i_read, bus.d_read | bus.d_write, m_last) && bus.d_write;
            m_addr  <= (winner(bus.i_read, bus.d_read | bus.d_write, m_last) ? bus.d_addr : bus.i_addr)
                       & ~C_LINE_MASK;
            m_wdata <= bus.d_wdata;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("mem_read",  LW'(bus.mem_read),  LW'(m_busy && !m_write));
        check("mem_write", LW'(bus.mem_write), LW'(m_busy &&  m_write));
        check("i_resp",    LW'(bus.i_resp),    LW'(m_resp == 1));
        check("d_resp",    LW'(bus.d_resp),    LW'(m_resp == 2));
        check("i_rdata",   bus.i_rdata,        m_irdata);
        check("d_rdata",   bus.d_rdata,        m_drdata);
        if (m_busy) begin
            check("mem_addr", LW'(bus.mem_addr), LW'(m_addr));
            if (m_write) check("mem_wdata", bus.mem_wdata, m_wdata);
        end
    end

    // ---------------- memory responder ----------------
    // Raises mem_resp on the mem_lat-th cycle a strobe is seen; read data is
    // the line address replicated across the line.
    bit mem_auto = 1'b1;
    int mem_lat  = 3;
    int mem_cnt  = 0;

    initial begin
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!mem_auto) begin
                mem_cnt = 0;
            end else if (bus.mem_resp) begin
                bus.mem_resp = 1'b0;
                mem_cnt      = 0;
            end else if (bus.mem_read || bus.mem_write) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = {(LW/AW){bus.mem_addr}};
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // ---------------- requesters ----------------
    // Latency is counted in negedges from the drive point; the cycle the
    // request is sampled is cycle 0.
    task automatic i_request(input logic [AW-1:0] a, output int lat);
        bus.i_read = 1'b1;
        bus.i_addr = a;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (bus.i_resp) begin
                lat = n;
                break;
            end
        end
        bus.i_read = 1'b0;
        if (lat < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL i_request timeout: got no i_resp, expected one within 200 cycles");
        end
    endtask

    task automatic d_request(input logic [AW-1:0] a, input logic rd, input logic wr,
                             input logic [LW-1:0] wd, output int lat);
        bus.d_read  = rd;
        bus.d_write = wr;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (bus.d_resp) begin
                lat = n;
                break;
            end
        end
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        if (lat < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL d_request timeout: got no d_resp, expected one within 200 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int li;
        int ld;
        logic [LW-1:0] pat_b;
        logic [LW-1:0] pat_c;
        pat_b = {(LW/AW){32'hDEAD_BEEF}};
        pat_c = {(LW/AW){32'h1357_9BDF}};

        bus.i_read  = 1'b0;
        bus.i_addr  = '0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset mem_read", LW'(bus.mem_read), '0);
        check("reset i_resp",   LW'(bus.i_resp),   '0);
        check("reset i_rdata",  bus.i_rdata,       '0);
        check("reset d_rdata",  bus.d_rdata,       '0);
        rst = 1'b0;
        @(negedge clk);

        // I-side fill, memory answers in the third serve cycle
        fork
            i_request(32'h0000_1234, li);
            begin
                @(negedge clk);
                check("t1 mem_read c1", LW'(bus.mem_read), LW'(1));
                check("t1 mem_addr",    LW'(bus.mem_addr), LW'(32'h0000_1220));
                repeat (2) @(negedge clk);
                check("t1 mem_read c3", LW'(bus.mem_read), LW'(1));
                @(negedge clk);
                check("t1 mem_read c4", LW'(bus.mem_read), LW'(0));
            end
        join
        check("t1 i_resp cycle", LW'(li), LW'(4));
        check("t1 i_rdata", bus.i_rdata, {(LW/AW){32'h0000_1220}});
        @(negedge clk);

        // D-side writeback
        fork
            d_request(32'h8000_0040, 1'b0, 1'b1, pat_b, ld);
            begin
                @(negedge clk);
                check("t2 mem_write", LW'(bus.mem_write), LW'(1));
                check("t2 mem_read",  LW'(bus.mem_read),  LW'(0));
                check("t2 mem_addr",  LW'(bus.mem_addr),  LW'(32'h8000_0040));
                check("t2 mem_wdata", bus.mem_wdata,      pat_b);
            end
        join
        check("t2 d_resp cycle", LW'(ld), LW'(4));
        @(negedge clk);

        // Contention from reset: I first, D after one idle cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fork
            i_request(32'h0000_0100, li);
            d_request(32'h0000_0200, 1'b1, 1'b0, '0, ld);
        join
        check("t3 I first",  LW'(li), LW'(4));
        check("t3 D second", LW'(ld), LW'(9));
        @(negedge clk);

        // I alone leaves I as last winner, so the next contention goes to D
        i_request(32'h0000_0300, li);
        check("t3b solo I", LW'(li), LW'(4));
        @(negedge clk);
        fork
            i_request(32'h0000_0400, li);
            d_request(32'h0000_0500, 1'b1, 1'b0, '0, ld);
        join
        check("t3c D first",  LW'(ld), LW'(4));
        check("t3c I second", LW'(li), LW'(9));
        check("t3c d_rdata",  bus.d_rdata, {(LW/AW){32'h0000_0500}});
        @(negedge clk);

        // Read and write together behave as a write
        fork
            d_request(32'h0000_0C3F, 1'b1, 1'b1, pat_c, ld);
            begin
                @(negedge clk);
                check("t4 mem_write", LW'(bus.mem_write), LW'(1));
                check("t4 mem_read",  LW'(bus.mem_read),  LW'(0));
                check("t4 mem_addr",  LW'(bus.mem_addr),  LW'(32'h0000_0C20));
            end
        join
        @(negedge clk);

        // Asynchronous reset in the middle of a D read
        mem_auto    = 1'b0;
        bus.d_read  = 1'b1;
        bus.d_addr  = 32'h0000_0600;
        @(negedge clk);
        check("t5 serving", LW'(bus.mem_read), LW'(1));
        @(negedge clk);
        #2;
        rst          = 1'b1;
        bus.mem_resp = 1'b1;
        #1;
        check("t5 async mem_read",  LW'(bus.mem_read),  '0);
        check("t5 async mem_write", LW'(bus.mem_write), '0);
        check("t5 async i_rdata",   bus.i_rdata,        '0);
        check("t5 async d_rdata",   bus.d_rdata,        '0);
        bus.d_read = 1'b0;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        check("t5 stale d_resp", LW'(bus.d_resp), '0);
        mem_auto = 1'b1;
        i_request(32'h0000_2000, li);
        check("t5 post-reset I", LW'(li), LW'(4));
        @(negedge clk);

        // mem_resp while idle is ignored
        mem_auto     = 1'b0;
        bus.mem_resp = 1'b1;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        @(negedge clk);
        check("t6 i_resp", LW'(bus.i_resp), '0);
        check("t6 d_resp", LW'(bus.d_resp), '0);
        mem_auto = 1'b1;
        i_request(32'h0000_5000, li);
        check("t6 still idle", LW'(li), LW'(4));
        check("t6 i_rdata", bus.i_rdata, {(LW/AW){32'h0000_5000}});

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
